// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift/rotate ops, plus iterative signed
// MUL and DIV that return a 2*WIDTH result through a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           opperation_signal,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   C,
    output logic                 div_by_zero
);

    localparam logic [4:0] OP_ADD  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01010;
    localparam logic [4:0] OP_ROR  = 5'b01011;
    localparam logic [4:0] OP_ROL  = 5'b01100;
    localparam logic [4:0] OP_ADDI = 5'b01101;
    localparam logic [4:0] OP_ANDI = 5'b01110;
    localparam logic [4:0] OP_ORI  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b10001;
    localparam logic [4:0] OP_NEG  = 5'b10010;
    localparam logic [4:0] OP_NOT  = 5'b10011;
    localparam logic [4:0] OP_INC  = 5'b11111;

    // The extra count value after the last shift step is the sign-fixup cycle.
    localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               stateQ, stateD;
    logic [4:0]           opQ, opD;
    logic [SHW:0]         cntQ, cntD;
    logic [2*WIDTH-1:0]   workAQ, workAD;
    logic [WIDTH-1:0]     workBQ, workBD;
    logic [2*WIDTH-1:0]   accQ, accD;
    logic                 signResQ, signResD;
    logic                 signRemQ, signRemD;
    logic [2*WIDTH-1:0]   resultQ, resultD;
    logic                 dbzQ, dbzD;

    logic [WIDTH-1:0]     singleRes;
    logic [WIDTH-1:0]     absA, absB;
    logic [2*WIDTH-1:0]   rorWide, rolWide;
    logic                 bTooBig;
    logic                 accept;
    logic                 isIterative;
    logic [WIDTH:0]       remShift, divisorExt, remSub;
    logic [WIDTH-1:0]     quotMag, remMag;

    assign busy        = (stateQ == RUN);
    assign done        = (stateQ == DONE);
    assign C           = resultQ;
    assign div_by_zero = dbzQ;

    assign accept      = start && (stateQ != RUN);
    assign isIterative = (opperation_signal == OP_MUL) ||
                         ((opperation_signal == OP_DIV) && (B != '0));

    // Result of the one-cycle opcodes, computed straight from the live operands.
    always_comb begin
        singleRes = '0;
        absA      = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
        absB      = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
        bTooBig   = |B[WIDTH-1:SHW];
        rorWide   = {A, A} >> B[SHW-1:0];
        rolWide   = {A, A} << B[SHW-1:0];
        case (opperation_signal)
            OP_ADD, OP_ADDI: singleRes = A + B;
            OP_SUB:          singleRes = A - B;
            OP_AND, OP_ANDI: singleRes = A & B;
            OP_OR,  OP_ORI:  singleRes = A | B;
            OP_SHR:          singleRes = bTooBig ? '0 : (A >> B[SHW-1:0]);
            OP_SHL:          singleRes = bTooBig ? '0 : (A << B[SHW-1:0]);
            OP_ROR:          singleRes = rorWide[WIDTH-1:0];
            OP_ROL:          singleRes = rolWide[2*WIDTH-1:WIDTH];
            OP_NEG:          singleRes = ~A + WIDTH'(1);
            OP_NOT:          singleRes = ~A;
            OP_INC:          singleRes = A + WIDTH'(1);
            default:         singleRes = '0;
        endcase
    end

    // One restoring-division step: shift the next dividend bit into the remainder.
    always_comb begin
        remShift   = {accQ[WIDTH-1:0], workAQ[WIDTH-1]};
        divisorExt = {1'b0, workBQ};
        remSub     = remShift - divisorExt;
        quotMag    = workAQ[WIDTH-1:0];
        remMag     = accQ[WIDTH-1:0];
    end

    // Next-state logic: operand capture on accept, one iteration per RUN cycle.
    always_comb begin
        stateD   = stateQ;
        opD      = opQ;
        cntD     = cntQ;
        workAD   = workAQ;
        workBD   = workBQ;
        accD     = accQ;
        signResD = signResQ;
        signRemD = signRemQ;
        resultD  = resultQ;
        dbzD     = dbzQ;
        case (stateQ)
            IDLE, DONE: begin
                if (accept) begin
                    opD  = opperation_signal;
                    dbzD = 1'b0;
                    if (isIterative) begin
                        stateD   = RUN;
                        cntD     = '0;
                        workAD   = {{WIDTH{1'b0}}, absA};
                        workBD   = absB;
                        accD     = '0;
                        signResD = A[WIDTH-1] ^ B[WIDTH-1];
                        signRemD = A[WIDTH-1];
                    end else if (opperation_signal == OP_DIV) begin
                        stateD  = DONE;
                        resultD = {A, {WIDTH{1'b1}}};
                        dbzD    = 1'b1;
                    end else begin
                        stateD  = DONE;
                        resultD = {{WIDTH{1'b0}}, singleRes};
                    end
                end else if (stateQ == DONE) begin
                    stateD = IDLE;
                end
            end
            RUN: begin
                if (cntQ == LAST_STEP) begin
                    stateD = DONE;
                    if (opQ == OP_MUL) begin
                        resultD = signResQ ? -accQ : accQ;
                    end else begin
                        resultD = {(signRemQ ? -remMag : remMag),
                                   (signResQ ? -quotMag : quotMag)};
                    end
                end else begin
                    cntD = cntQ + (SHW+1)'(1);
                    if (opQ == OP_MUL) begin
                        if (workBQ[0]) begin
                            accD = accQ + workAQ;
                        end
                        workAD = workAQ << 1;
                        workBD = workBQ >> 1;
                    end else begin
                        accD = '0;
                        if (remShift >= divisorExt) begin
                            accD[WIDTH:0] = remSub;
                            workAD = {{WIDTH{1'b0}}, workAQ[WIDTH-2:0], 1'b1};
                        end else begin
                            accD[WIDTH:0] = remShift;
                            workAD = {{WIDTH{1'b0}}, workAQ[WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= IDLE;
            opQ      <= '0;
            cntQ     <= '0;
            workAQ   <= '0;
            workBQ   <= '0;
            accQ     <= '0;
            signResQ <= 1'b0;
            signRemQ <= 1'b0;
            resultQ  <= '0;
            dbzQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            opQ      <= opD;
            cntQ     <= cntD;
            workAQ   <= workAD;
            workBQ   <= workBD;
            accQ     <= accD;
            signResQ <= signResD;
            signRemQ <= signRemD;
            resultQ  <= resultD;
            dbzQ     <= dbzD;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32.
module tb_seq_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  opSig;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        busy;
    logic        done;
    logic [63:0] cOut;
    logic        dbz;

    int vectors;
    int miscompares;
    int cycles;
    int doneSeen;

    seq_alu #(.WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .opperation_signal (opSig),
        .A                 (aIn),
        .B                 (bIn),
        .busy              (busy),
        .done              (done),
        .C                 (cOut),
        .div_by_zero       (dbz)
    );

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one request at the falling edge; return 1ns after the accepting edge.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        opSig = op;
        aIn   = a;
        bIn   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, scrambling the inputs while the iteration runs.
    task automatic waitDone(output int count);
        count = 0;
        while (done !== 1'b1 && count < 100) begin
            @(posedge clk);
            #1;
            count++;
            if (done !== 1'b1) begin
                aIn   = $urandom;
                bIn   = $urandom;
                opSig = 5'($urandom);
                start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
    endtask

    task automatic runSingle(input string tag, input logic [4:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] expC);
        applyStimulus(op, a, b);
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
        checkOutput({tag, "_C"}, cOut, expC);
    endtask

    task automatic runIter(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expC);
        int n;
        applyStimulus(op, a, b);
        checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd1);
        checkOutput({tag, "_doneLow"}, {63'd0, done}, 64'd0);
        waitDone(n);
        checkOutput({tag, "_latency"}, 64'(n), 64'd33);
        checkOutput({tag, "_C"}, cOut, expC);
        checkOutput({tag, "_busyEnd"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        opSig = 5'd0;
        aIn   = 32'd0;
        bIn   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_C", cOut, 64'd0);
        checkOutput("rst_dbz", {63'd0, dbz}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        runSingle("add_wrap", 5'b00101, 32'hFFFF_FFFF, 32'd2, 64'h0000_0000_0000_0001);
        checkOutput("add_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("add_donePulse", {63'd0, done}, 64'd0);
        checkOutput("add_hold", cOut, 64'h0000_0000_0000_0001);

        runIter("mul_neg", 5'b10000, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        @(posedge clk);
        #1;
        checkOutput("mul_donePulse", {63'd0, done}, 64'd0);
        checkOutput("mul_hold", cOut, 64'hFFFF_FFFF_FFFF_FFEB);

        runIter("mul_max", 5'b10000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        runIter("mul_min", 5'b10000, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        runIter("div_neg", 5'b10001, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("div_neg_dbz", {63'd0, dbz}, 64'd0);
        runIter("div_ovf", 5'b10001, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        runIter("div_pos", 5'b10001, 32'd100, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2);

        runSingle("div_zero", 5'b10001, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        checkOutput("div_zero_dbz", {63'd0, dbz}, 64'd1);
        checkOutput("div_zero_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("dbz_hold", {63'd0, dbz}, 64'd1);
        runSingle("add_clr", 5'b00101, 32'd3, 32'd4, 64'd7);
        checkOutput("add_clr_dbz", {63'd0, dbz}, 64'd0);

        runSingle("ror_33", 5'b01011, 32'h0000_0001, 32'd33, 64'h0000_0000_8000_0000);
        runSingle("rol_1", 5'b01100, 32'h8000_0000, 32'd1, 64'd1);
        runSingle("shl_40", 5'b01010, 32'd1, 32'd40, 64'd0);
        runSingle("shr_31", 5'b01001, 32'h8000_0000, 32'd31, 64'd1);
        runSingle("shr_32", 5'b01001, 32'h8000_0000, 32'd32, 64'd0);
        runSingle("sub", 5'b00110, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE);
        runSingle("and", 5'b01110, 32'hF0F0_1234, 32'h0FF0_FF00, 64'h0000_0000_00F0_1200);
        runSingle("or", 5'b01000, 32'hF000_0001, 32'h0000_0F00, 64'h0000_0000_F000_0F01);
        runSingle("neg", 5'b10010, 32'd5, 32'd0, 64'h0000_0000_FFFF_FFFB);
        runSingle("not", 5'b10011, 32'h0000_0000, 32'd9, 64'h0000_0000_FFFF_FFFF);
        runSingle("inc", 5'b11111, 32'hFFFF_FFFF, 32'd0, 64'd0);
        runSingle("nop", 5'b11110, 32'h1234_5678, 32'd1, 64'd0);

        // MUL started from DONE: done must drop on the next cycle.
        runSingle("addi_pre", 5'b01101, 32'd10, 32'd20, 64'd30);
        runIter("mul_b2b", 5'b10000, 32'd6, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF4);

        // Reset in the middle of a multiply.
        applyStimulus(5'b10000, 32'd1000, 32'd1000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstmul_busy", {63'd0, busy}, 64'd0);
        checkOutput("rstmul_done", {63'd0, done}, 64'd0);
        checkOutput("rstmul_C", cOut, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("rstmul_noDone", 64'(doneSeen), 64'd0);
        runSingle("add_after", 5'b00101, 32'd1, 32'd1, 64'd2);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        reset = 1'b1;
        opSig = 5'b00101;
        aIn   = 32'd5;
        bIn   = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("rststart_done", {63'd0, done}, 64'd0);
        checkOutput("rststart_C", cOut, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
